// File: rtl/rfphoenix_branch_predictor.sv
// Gshare direction predictor: 2-bit counter table indexed by PC ^ global history,
// with a power-on sweep, speculative history shift and mispredict repair.
module rfphoenix_branch_predictor #(
  parameter int AWID     = 32,
  parameter int TBL_BITS = 10,
  parameter int GHR_BITS = 8,
  parameter int PC_LSB   = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                rdy_o,
  input  logic                pred_req_i,
  input  logic [AWID-1:0]     pred_pc_i,
  output logic                pred_v_o,
  output logic                pred_taken_o,
  output logic [GHR_BITS-1:0] pred_ghr_o,
  input  logic                upd_v_i,
  input  logic [AWID-1:0]     upd_pc_i,
  input  logic [GHR_BITS-1:0] upd_ghr_i,
  input  logic                upd_taken_i,
  input  logic                upd_mispred_i
);

  localparam int ENTRIES = 1 << TBL_BITS;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state;
  logic [TBL_BITS-1:0] sweep;
  logic [GHR_BITS-1:0] ghr;
  logic [1:0]          cnt [ENTRIES];

  logic [TBL_BITS-1:0] pidx, uidx;
  logic                p_bit;
  logic [1:0]          ucnt, unext;
  logic                run, acc_req, acc_upd;

  // History is zero-extended into the index width, so GHR_BITS == TBL_BITS needs no special case.
  function automatic logic [TBL_BITS-1:0] idx(input logic [AWID-1:0] pc,
                                              input logic [GHR_BITS-1:0] h);
    logic [TBL_BITS-1:0] hx;
    hx = '0;
    hx[GHR_BITS-1:0] = h;
    return pc[PC_LSB +: TBL_BITS] ^ hx;
  endfunction

  // Only the index field of each PC matters; the rest is intentionally dropped.
  logic unused_pc;
  assign unused_pc = ^{pred_pc_i, upd_pc_i};

  assign run     = (state == ST_RUN);
  assign rdy_o   = run;
  assign acc_req = run & pred_req_i;
  assign acc_upd = run & upd_v_i;

  always_comb begin
    pidx  = idx(pred_pc_i, ghr);
    uidx  = idx(upd_pc_i, upd_ghr_i);
    p_bit = cnt[pidx][1];
    ucnt  = cnt[uidx];
    unext = ucnt;
    if (upd_taken_i) begin
      if (ucnt != 2'b11) unext = ucnt + 2'b01;
    end else begin
      if (ucnt != 2'b00) unext = ucnt - 2'b01;
    end
  end

  // Table has no reset of its own; the INIT sweep gives it a known value.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (!run)         cnt[sweep] <= 2'b01;
      else if (acc_upd) cnt[uidx]  <= unext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= ST_INIT;
      sweep        <= '0;
      ghr          <= '0;
      pred_v_o     <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_ghr_o   <= '0;
    end else begin
      pred_v_o <= acc_req;
      if (!run) begin
        sweep <= sweep + 1'b1;
        if (sweep == '1) state <= ST_RUN;
      end
      if (acc_req) begin
        pred_taken_o <= p_bit;
        pred_ghr_o   <= ghr;
      end
      // Repair outranks the speculative shift of a same-cycle request.
      if (acc_upd && upd_mispred_i)
        ghr <= {upd_ghr_i[GHR_BITS-2:0], upd_taken_i};
      else if (acc_req)
        ghr <= {ghr[GHR_BITS-2:0], p_bit};
    end
  end

endmodule

// File: tb/tb_rfphoenix_branch_predictor.sv
// Directed bench for the gshare predictor with a 16-entry table and 4-bit history.
module tb_rfphoenix_branch_predictor;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rdy_o;
  logic        pred_req_i;
  logic [31:0] pred_pc_i;
  logic        pred_v_o;
  logic        pred_taken_o;
  logic [3:0]  pred_ghr_o;
  logic        upd_v_i;
  logic [31:0] upd_pc_i;
  logic [3:0]  upd_ghr_i;
  logic        upd_taken_i;
  logic        upd_mispred_i;

  int checks = 0;
  int failures = 0;

  rfphoenix_branch_predictor #(.AWID(32), .TBL_BITS(4), .GHR_BITS(4), .PC_LSB(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rdy_o(rdy_o),
    .pred_req_i(pred_req_i), .pred_pc_i(pred_pc_i), .pred_v_o(pred_v_o),
    .pred_taken_o(pred_taken_o), .pred_ghr_o(pred_ghr_o),
    .upd_v_i(upd_v_i), .upd_pc_i(upd_pc_i), .upd_ghr_i(upd_ghr_i),
    .upd_taken_i(upd_taken_i), .upd_mispred_i(upd_mispred_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Wait out the init sweep; optionally hammer requests/updates that must be ignored.
  task automatic init_wait(input bit poke, input string tag);
    int n = 0;
    int pv = 0;
    if (poke) begin
      pred_req_i = 1; pred_pc_i = 32'h5;
      upd_v_i = 1; upd_pc_i = 32'h5; upd_ghr_i = 4'b0011;
      upd_taken_i = 1; upd_mispred_i = 1;
    end
    while (!rdy_o && n < 100) begin
      tick();
      n++;
      if (pred_v_o) pv++;
    end
    pred_req_i = 0; upd_v_i = 0; upd_mispred_i = 0; upd_taken_i = 0;
    chk({tag, "_init_cycles"}, n, 16);
    chk({tag, "_pv_during_init"}, pv, 0);
  endtask

  task automatic pred(input logic [31:0] pc, input logic et, input logic [3:0] eg,
                      input string tag);
    pred_req_i = 1; pred_pc_i = pc;
    tick();
    pred_req_i = 0;
    chk({tag, "_v"}, pred_v_o, 1);
    chk({tag, "_taken"}, pred_taken_o, et);
    chk({tag, "_ghr"}, pred_ghr_o, eg);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] g, input logic t,
                     input logic m);
    upd_v_i = 1; upd_pc_i = pc; upd_ghr_i = g; upd_taken_i = t; upd_mispred_i = m;
    tick();
    upd_v_i = 0; upd_mispred_i = 0;
  endtask

  initial begin
    rst_ni = 0; pred_req_i = 0; pred_pc_i = 0; upd_v_i = 0; upd_pc_i = 0;
    upd_ghr_i = 0; upd_taken_i = 0; upd_mispred_i = 0;
    tick(); tick();
    chk("rst_rdy", rdy_o, 0);
    chk("rst_pv", pred_v_o, 0);
    chk("rst_taken", pred_taken_o, 0);
    chk("rst_ghr", pred_ghr_o, 0);

    // Requests/updates during init are ignored; entry 5 stays weakly not-taken.
    rst_ni = 1;
    init_wait(1'b1, "t6");
    pred(32'h5, 0, 4'h0, "t6_p5");

    // Every entry starts at 01; back-to-back not-taken keeps history at 0.
    for (int i = 0; i < 16; i++) pred(32'(i), 0, 4'h0, $sformatf("t1_p%0d", i));
    tick();
    chk("t1_idle_pv", pred_v_o, 0);
    chk("t1_idle_hold", pred_taken_o, 0);
    chk("t1_upper_pc", 32'(dut.rdy_o), 1);

    // Saturation on index 5; PCs chosen as 5^ghr to keep hitting index 5.
    upd(32'h5, 4'h0, 1, 0);
    upd(32'h5, 4'h0, 1, 0);
    pred(32'h5, 1, 4'h0, "t2_sat11");       // ghr -> 0001
    upd(32'h5, 4'h0, 1, 0);
    pred(32'h4, 1, 4'h1, "t2_stay11");      // ghr -> 0011
    upd(32'h5, 4'h0, 0, 0);
    upd(32'h5, 4'h0, 0, 0);
    upd(32'h5, 4'h0, 0, 0);
    pred(32'h6, 0, 4'h3, "t2_sat00");       // ghr -> 0110
    upd(32'h5, 4'h0, 0, 0);
    pred(32'h3, 0, 4'h6, "t2_stay00");      // ghr -> 1100
    pred(32'hFFFF_FFF9, 0, 4'hC, "t2_upper_pc"); // idx 9^C=5, ghr -> 1000

    // Repair history to 0, then bring index 5 back to 01.
    upd(32'h5, 4'h0, 0, 1);
    upd(32'h5, 4'h0, 1, 0);

    // Collision: prediction sees the old counter, the update still lands.
    pred_req_i = 1; pred_pc_i = 32'h5;
    upd_v_i = 1; upd_pc_i = 32'h5; upd_ghr_i = 4'h0; upd_taken_i = 1; upd_mispred_i = 0;
    tick();
    pred_req_i = 0; upd_v_i = 0;
    chk("t3_coll_v", pred_v_o, 1);
    chk("t3_coll_old", pred_taken_o, 0);
    pred(32'h5, 1, 4'h0, "t3_after");       // ghr -> 0001

    // Repair wins over speculative shift; request still predicts (idx A^1=B -> 01).
    pred_req_i = 1; pred_pc_i = 32'hA;
    upd_v_i = 1; upd_pc_i = 32'hC; upd_ghr_i = 4'b0011; upd_taken_i = 1; upd_mispred_i = 1;
    tick();
    pred_req_i = 0; upd_v_i = 0; upd_mispred_i = 0;
    chk("t4_req_v", pred_v_o, 1);
    chk("t4_req_taken", pred_taken_o, 0);
    chk("t4_req_ghr", pred_ghr_o, 4'h1);
    pred(32'h0, 0, 4'h7, "t4_repaired");    // ghr -> 1110
    pred(32'h1, 1, 4'hE, "t4_upd_F");       // idx 1^E=F was trained, ghr -> 1101

    // Reset mid-init restarts the sweep and clears everything.
    rst_ni = 0; tick(); rst_ni = 1;
    chk("t5_rst_taken", pred_taken_o, 0);
    chk("t5_rst_ghr", pred_ghr_o, 0);
    repeat (7) tick();
    chk("t5_mid_rdy", rdy_o, 0);
    rst_ni = 0; tick(); rst_ni = 1;
    chk("t5_rst2_rdy", rdy_o, 0);
    init_wait(1'b0, "t5");
    for (int i = 0; i < 16; i++) pred(32'(i), 0, 4'h0, $sformatf("t5_p%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
